int_sequencer: RTL
==================

INT_SEQUENCER -- requirements
Module: int_sequencer

Interface
REQ-001 The module SHALL have parameter pcWidth, default 16, giving the width of PC, vector and memory address/data paths.
REQ-002 The module SHALL have parameter saveAddr, default 16'hFFFE, giving the fixed memory word where the interrupted PC is saved.
REQ-003 The module SHALL have one clock and an asynchronous active-low reset, as these ports:
- clk  in  1  system clock; all state changes on rising edge.
- rstN  in  1  asynchronous active-low reset.
- intPending  in  1  a masked interrupt is pending (from the prioritized vectored interrupt block).
- intAddr  in  pcWidth  ISR vector address from the interrupt block.
- instrDone  in  1  CPU is at an instruction boundary this cycle.
- pc  in  pcWidth  current CPU PC (address of next instruction).
- reti  in  1  CPU executed return-from-interrupt (1-cycle pulse).
- memAck  in  1  memory completed the current request.
- memRData  in  pcWidth  memory read data, valid when memAck=1.
- memReq  out  1  memory request.
- memWe  out  1  1=write, 0=read; valid while memReq=1.
- memAddr  out  pcWidth  request address.
- memWData  out  pcWidth  write data.
- pcLoad  out  1  1-cycle pulse: CPU loads pcNext.
- pcNext  out  pcWidth  PC value to load.
- ldIntReg, clrIntReg, pendClr, intDisable  out  1 each  control strobes/level to the interrupt block.
- cpuStall  out  1  CPU holds its PC and does not fetch.
- inIsr  out  1  an ISR is active.

Function
REQ-004 The FSM SHALL have states IDLE, LATCH, PUSH, VECTOR, ISR, POP, RESTORE; it is single-level (no nesting).
REQ-005 IDLE: when intPending=1 and instrDone=1 on the same edge, the FSM SHALL go to LATCH, capturing pc into savedPc; otherwise it SHALL stay in IDLE.
REQ-006 LATCH (1 cycle): ldIntReg=1, cpuStall=1, intDisable=1; next state PUSH unconditionally; intPending dropping here SHALL NOT abort the sequence.
REQ-007 PUSH: memReq=1, memWe=1, memAddr=saveAddr, memWData=savedPc, held stable until an edge with memAck=1; then VECTOR.
REQ-008 memAck SHALL count only on an edge where memReq=1; memAck with memReq=0 SHALL be ignored; memAck in the first memReq cycle SHALL complete the request (zero-wait allowed).
REQ-009 VECTOR (1 cycle): pcLoad=1, pcNext=intAddr, clrIntReg=1, pendClr=1; next state ISR.
REQ-010 ISR: inIsr=1, intDisable=1, cpuStall=0; on reti=1 next state POP; intPending is ignored.
REQ-011 POP: memReq=1, memWe=0, memAddr=saveAddr, cpuStall=1; on memAck the FSM SHALL register memRData into savedPc and go to RESTORE.
REQ-012 RESTORE (1 cycle): pcLoad=1, pcNext=savedPc; next state IDLE; intDisable deasserts on entry to IDLE.
REQ-013 cpuStall SHALL be 1 in LATCH, PUSH, VECTOR, POP, RESTORE and 0 in IDLE and ISR.
REQ-014 Strobes ldIntReg, clrIntReg, pendClr, pcLoad SHALL be exactly 1 cycle per sequence; intDisable SHALL be 1 in every state except IDLE.
REQ-015 reti outside ISR SHALL be ignored, with no state or output change.
REQ-016 In IDLE, an interrupt SHALL be taken the same edge instrDone coincides with intPending; the minimum latency from that edge to pcLoad SHALL be 3 cycles (LATCH, PUSH with zero-wait ack, VECTOR).
REQ-017 When not driven by the active state, memReq/memWe/pcLoad SHALL be 0, memAddr/memWData/pcNext SHALL be 0.

Reset
REQ-018 rstN=0 SHALL immediately force state IDLE, savedPc=0, and all outputs 0 regardless of clk.
REQ-019 Reset mid-sequence (any state) SHALL abandon the sequence with no further memory request or pcLoad after release.
REQ-020 After rstN rises, the first possible transition SHALL be on the following rising clk edge.

Verification
REQ-021 pc=16'h0120, intAddr=16'h0040, intPending=1, instrDone=1, memAck tied 1 -> LATCH, write 16'h0120 to 16'hFFFE, pcLoad with pcNext=16'h0040 three cycles after the trigger edge; single pulses of ldIntReg/clrIntReg/pendClr.
REQ-022 PUSH with memAck delayed 4 cycles -> memReq/memAddr/memWData stable 5 cycles, VECTOR only after the ack edge.
REQ-023 In ISR, reti pulse, memRData=16'h0120 with ack after 2 cycles -> pcLoad with pcNext=16'h0120, then IDLE with intDisable=0, inIsr=0.
REQ-024 reti in IDLE, and intPending=1 with instrDone=0 for 10 cycles -> no state change, no memReq, no pcLoad.
REQ-025 rstN low during PUSH with memReq=1 -> memReq=0 asynchronously; after release no pcLoad occurs and state is IDLE.
REQ-026 intPending asserted during ISR, then reti -> restore completes, returns to IDLE, new interrupt taken on the next instrDone.

Source files
------------

// File: rtl/int_sequencer.sv
// Interrupt entry/exit sequencer: saves the interrupted PC to a fixed memory word,
// vectors the CPU to the ISR, and restores the PC when the ISR returns.
module int_sequencer #(
  parameter int unsigned          pcWidth  = 16,
  parameter logic [pcWidth-1:0]   saveAddr = 16'hFFFE
) (
  input  logic               clk,
  input  logic               rstN,
  input  logic               intPending,
  input  logic [pcWidth-1:0] intAddr,
  input  logic               instrDone,
  input  logic [pcWidth-1:0] pc,
  input  logic               reti,
  input  logic               memAck,
  input  logic [pcWidth-1:0] memRData,
  output logic               memReq,
  output logic               memWe,
  output logic [pcWidth-1:0] memAddr,
  output logic [pcWidth-1:0] memWData,
  output logic               pcLoad,
  output logic [pcWidth-1:0] pcNext,
  output logic               ldIntReg,
  output logic               clrIntReg,
  output logic               pendClr,
  output logic               intDisable,
  output logic               cpuStall,
  output logic               inIsr,
  output logic [2:0]         dbgState
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LATCH   = 3'd1,
    PUSH    = 3'd2,
    VECTOR  = 3'd3,
    ISR     = 3'd4,
    POP     = 3'd5,
    RESTORE = 3'd6
  } state_e;

  state_e             state_q, state_d;
  logic [pcWidth-1:0] savedPc_q, savedPc_d;
  logic               memDone;

  // Memory handshake: memReq is held with stable address/data until an edge where
  // memAck=1 while memReq=1; that edge completes the request (zero-wait allowed).
  assign memDone  = memReq & memAck;
  assign dbgState = state_q;

  always_comb begin
    state_d   = state_q;
    savedPc_d = savedPc_q;
    case (state_q)
      IDLE: begin
        if (intPending && instrDone) begin
          state_d   = LATCH;
          savedPc_d = pc;
        end
      end
      LATCH:   state_d = PUSH;
      PUSH:    if (memDone) state_d = VECTOR;
      VECTOR:  state_d = ISR;
      ISR:     if (reti) state_d = POP;
      POP: begin
        if (memDone) begin
          state_d   = RESTORE;
          savedPc_d = memRData;
        end
      end
      RESTORE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so each one is a clean decode of
  // the state the FSM is actually in during that cycle.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q    <= IDLE;
      savedPc_q  <= '0;
      memReq     <= 1'b0;
      memWe      <= 1'b0;
      memAddr    <= '0;
      memWData   <= '0;
      pcLoad     <= 1'b0;
      pcNext     <= '0;
      ldIntReg   <= 1'b0;
      clrIntReg  <= 1'b0;
      pendClr    <= 1'b0;
      intDisable <= 1'b0;
      cpuStall   <= 1'b0;
      inIsr      <= 1'b0;
    end else begin
      state_q    <= state_d;
      savedPc_q  <= savedPc_d;
      memReq     <= (state_d == PUSH) || (state_d == POP);
      memWe      <= (state_d == PUSH);
      memAddr    <= ((state_d == PUSH) || (state_d == POP)) ? saveAddr : '0;
      memWData   <= (state_d == PUSH) ? savedPc_d : '0;
      pcLoad     <= (state_d == VECTOR) || (state_d == RESTORE);
      pcNext     <= (state_d == VECTOR)  ? intAddr   :
                    (state_d == RESTORE) ? savedPc_d : '0;
      ldIntReg   <= (state_d == LATCH);
      clrIntReg  <= (state_d == VECTOR);
      pendClr    <= (state_d == VECTOR);
      intDisable <= (state_d != IDLE);
      cpuStall   <= (state_d != IDLE) && (state_d != ISR);
      inIsr      <= (state_d == ISR);
    end
  end

endmodule
